// File: rtl/outport_credit_tracker.sv
// Output-port stage behind one crossbar lane: registers the outgoing flit and
// tracks downstream credits plus packet ownership (IDLE/ACTIVE) for each VC.
module outport_credit_tracker #(
  parameter int V  = 4,
  parameter int Fw = 36,
  parameter int B  = 4,
  localparam int Cw = $clog2(B + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [Fw-1:0] flit_in,
  input  logic          flit_in_wr,
  input  logic [V-1:0]  vc_num_in,
  input  logic          hdr_in,
  input  logic          tail_in,
  input  logic [V-1:0]  credit_in,
  output logic [Fw-1:0] flit_out,
  output logic          flit_out_wr,
  output logic [V-1:0]  vc_out,
  output logic [V-1:0]  vc_avb,
  output logic [V-1:0]  vc_idle,
  output logic          err
);

  // Handshake: flit_in_wr is a valid with no ready; the upstream allocator
  // may only send when it holds a credit, and each credit_in bit returns one
  // buffer slot. Nothing here ever stalls the lane.
  localparam logic [Cw-1:0] CRED_MAX  = Cw'(B);
  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_ACTIVE = 1'b1;

  logic [Fw-1:0]         flit_out_q, flit_out_d;
  logic [V-1:0]          vc_out_q, vc_out_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [V-1:0][Cw-1:0]  credit_q, credit_d;
  logic [V-1:0]          state_q, state_d;
  logic                  sel_ok;
  logic                  hit, legal, take;

  always_comb begin
    sel_ok     = flit_in_wr && $onehot(vc_num_in);
    flit_out_d = flit_out_q;
    vc_out_d   = vc_out_q;
    wr_d       = sel_ok;
    err_d      = err_q;
    credit_d   = credit_q;
    state_d    = state_q;
    hit        = 1'b0;
    legal      = 1'b0;
    take       = 1'b0;
    if (sel_ok) begin
      flit_out_d = flit_in;
      vc_out_d   = vc_num_in;
    end
    if (flit_in_wr && !sel_ok) err_d = 1'b1;
    for (int v = 0; v < V; v++) begin
      hit   = sel_ok && vc_num_in[v];
      legal = (state_q[v] == ST_IDLE) ? hdr_in : !hdr_in;
      // A protocol-violating flit is still forwarded but leaves both the
      // ownership state and the credit count of its VC untouched.
      take  = hit && legal;
      if (hit && !legal) err_d = 1'b1;
      if (take) state_d[v] = tail_in ? ST_IDLE : ST_ACTIVE;
      if (take && !credit_in[v]) begin
        if (credit_q[v] == '0) err_d = 1'b1;
        else                   credit_d[v] = credit_q[v] - Cw'(1);
      end else if (!take && credit_in[v]) begin
        if (credit_q[v] == CRED_MAX) err_d = 1'b1;
        else                         credit_d[v] = credit_q[v] + Cw'(1);
      end
    end
  end

  always_comb begin
    vc_avb  = '0;
    vc_idle = '0;
    for (int v = 0; v < V; v++) begin
      vc_avb[v]  = (credit_q[v] != '0);
      vc_idle[v] = (state_q[v] == ST_IDLE) && (credit_q[v] == CRED_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flit_out_q <= '0;
      vc_out_q   <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      credit_q   <= {V{CRED_MAX}};
      state_q    <= {V{ST_IDLE}};
    end else begin
      flit_out_q <= flit_out_d;
      vc_out_q   <= vc_out_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      credit_q   <= credit_d;
      state_q    <= state_d;
    end
  end

  assign flit_out    = flit_out_q;
  assign vc_out      = vc_out_q;
  assign flit_out_wr = wr_q;
  assign err         = err_q;

endmodule

// File: doc/outport_credit_tracker.md
# outport_credit_tracker

Per-output-port stage that sits directly behind one crossbar output lane. It registers the flit selected by the crossbar toward the downstream link and keeps one credit counter and one packet-ownership state machine per downstream VC. It also returns availability and idle status to the VC and switch allocators. One instance exists per router output port. Credits arrive from the downstream router's input buffer.

## Interface
Parameters:
- V, 4, VCs per port
- Fw, 36, flit width
- B, 4, downstream buffer depth per VC (credits at reset); B >= 1
- Derived: Cw = log2(B+1), credit counter width

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; state initialises on any rising edge with reset=0
- flit_in  input  Fw  flit from the crossbar output lane
- flit_in_wr  input  1  flit_in valid this cycle
- vc_num_in  input  V  one-hot downstream VC of flit_in
- hdr_in  input  1  flit_in is a header flit
- tail_in  input  1  flit_in is a tail flit; hdr_in=tail_in=1 marks a single-flit packet
- credit_in  input  V  one credit returned per asserted bit
- flit_out  output  Fw  registered flit to the link
- flit_out_wr  output  1  registered write strobe to the link
- vc_out  output  V  registered VC of flit_out
- vc_avb  output  V  bit v = credit[v] > 0
- vc_idle  output  V  bit v = state IDLE and credit[v] == B
- err  output  1  sticky protocol error

## Operation
- Data path: when flit_in_wr=1 and vc_num_in is exactly one-hot, capture flit_in into flit_out and vc_num_in into vc_out, and pulse flit_out_wr.
- Otherwise flit_out_wr=0, and flit_out and vc_out hold their last values.
- Credit counter v, evaluated each cycle with w = accepted write to v and c = credit_in[v]:
  - w=1, c=0: decrement.
  - w=0, c=1: increment.
  - w=1, c=1: counter unchanged.
  - w=0, c=0: counter unchanged.
- Underflow: a write to v with credit[v]==0 and c=0 still forwards the flit, sets err, and the counter stays 0.
- Overflow: credit_in[v] with credit[v]==B and no write to v sets err, and the counter stays B.
- Per-VC FSM, states IDLE and ACTIVE:
  - IDLE, header, non-tail write: go to ACTIVE.
  - IDLE, header+tail write: stay IDLE.
  - ACTIVE, tail (non-header) write: go to IDLE.
  - ACTIVE, body write: stay ACTIVE.
  - Protocol violations set err and leave the state unchanged:
    - IDLE receiving body or tail-only.
    - ACTIVE receiving a header.
- Bad VC select: flit_in_wr=1 with vc_num_in zero or multi-hot sets err. No flit is forwarded and no counter or FSM changes.
- err is sticky. Only reset clears it.
- Different VCs update independently in the same cycle. Multiple credit_in bits may be set together.

## Timing
- Reset values:
  - flit_out=0, vc_out=0, flit_out_wr=0, err=0.
  - All credits = B, all FSMs IDLE.
  - vc_avb = all ones, vc_idle = all ones.
- Flit latency is 1 cycle: input at edge n appears on flit_out/flit_out_wr after edge n.
- Credit and status latency is 1 cycle. vc_avb and vc_idle are decoded combinationally from the registered counters and state only, with no combinational path from any input.
  - Consequence: a write at cycle n that consumes the last credit still shows vc_avb=1 during cycle n. The allocator must account for in-flight grants.
- Reset asserted mid-packet: all state returns to reset values on that edge. Any flit presented in the same cycle is dropped.
- Throughput: one flit per cycle, no backpressure. Flow control is credit-based only.

## Test plan
- Reset with V=4, B=4, reset held low 2 cycles -> vc_avb=4'b1111, vc_idle=4'b1111, err=0, flit_out_wr=0.
- 4-flit packet on VC1 (hdr, body, body, tail), back-to-back, no credits returned:
  - flit_out_wr pulses 4 consecutive cycles, each 1 cycle after its input; vc_out=4'b0010.
  - credit[1] goes 4→0 and vc_avb=4'b1101 one cycle after the tail.
  - vc_idle[1]=0 from the cycle after the header.
- Then return 4 credits on credit_in[1] over 4 cycles -> vc_avb[1]=1 after the first credit; vc_idle[1]=1 after the fourth.
- Write to VC2 with credit_in[2]=1 in the same cycle at credit 3 -> credit[2] stays 3, err=0.
- Fifth write to VC0 with 0 credits -> flit forwarded, err=1, credit[0] stays 0. Then credit_in[3] at credit 4 -> err stays 1, credit[3] stays 4.
- Protocol and select violations:
  - Body flit to IDLE VC3 -> err=1, vc_idle[3] stays 1.
  - flit_in_wr with vc_num_in=4'b0110 -> flit_out_wr=0, err=1, all counters unchanged.
- Reset pulled low mid-packet on VC1 (ACTIVE, credit 2) -> next cycle credit[1]=4, IDLE, err=0.
